// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file access controller.
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    // One buffered memory return waiting for the regfile write port.
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // Source operand: x0 reads zero, a write landing this cycle is forwarded,
    // otherwise the regfile read data is used.
    function automatic logic [XLEN-1:0] operand_sel(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rdata,
        input logic              wr,
        input logic [REG_AW-1:0] wraddr,
        input logic [XLEN-1:0]   wrdata
    );
        if (rs == '0)
            return '0;
        else if (wr && (wraddr == rs))
            return wrdata;
        else
            return rdata;
    endfunction

endpackage

// File: rtl/rf_access_ctrl_wb_fifo.sv
// Synchronous FIFO buffering memory returns until the write port is free.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  wb_entry_t i_push_data,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];

    // A push while full is legal only when the head leaves in the same cycle.
    assign push_ok = i_push && (!o_full || i_pop);
    assign pop_ok  = i_pop && !o_empty;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop_ok)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write.
    // NOTE: storage is deliberately not reset; the empty flag guards stale entries.
    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Register-file client: operand capture with bypass, write-port arbitration,
// long-latency scoreboard and RAW/WAW issue stall.
module rf_access_ctrl
    import rf_pkg::*;
#(
    parameter int WB_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_iss_valid,
    output logic              o_iss_ready,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_rd_we,
    input  logic              i_rd_long,
    output logic              o_op_valid,
    input  logic              i_op_ready,
    output logic [XLEN-1:0]   o_op_a,
    output logic [XLEN-1:0]   o_op_b,
    output logic [REG_AW-1:0] o_op_rd,
    output logic              o_op_rd_we,
    output logic              o_op_rd_long,
    output logic [REG_AW-1:0] o_rf_rdaddr1,
    output logic [REG_AW-1:0] o_rf_rdaddr2,
    input  logic [XLEN-1:0]   i_rf_rdata1,
    input  logic [XLEN-1:0]   i_rf_rdata2,
    output logic              o_rf_wr,
    output logic [REG_AW-1:0] o_rf_wraddr,
    output logic [XLEN-1:0]   o_rf_wrdata,
    input  logic              i_alu_wb_valid,
    input  logic [REG_AW-1:0] i_alu_wb_addr,
    input  logic [XLEN-1:0]   i_alu_wb_data,
    input  logic              i_mem_wb_valid,
    output logic              o_mem_wb_ready,
    input  logic [REG_AW-1:0] i_mem_wb_addr,
    input  logic [XLEN-1:0]   i_mem_wb_data
);

    wb_entry_t         fifo_head;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              mem_bypass, mem_write;
    logic [NREG-1:0]   busy_q, busy_d, set_vec, clear_vec, eff_busy;
    logic              hazard, accept;

    logic              op_valid_q, op_valid_d;
    logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [REG_AW-1:0] op_rd_q, op_rd_d;
    logic              op_rd_we_q, op_rd_we_d, op_rd_long_q, op_rd_long_d;

    wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (fifo_push),
        .i_push_data ('{addr: i_mem_wb_addr, data: i_mem_wb_data}),
        .i_pop       (fifo_pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    assign o_mem_wb_ready = !fifo_full;
    assign o_rf_rdaddr1   = i_rs1;
    assign o_rf_rdaddr2   = i_rs2;

    // Write-port arbitration: ALU first, then FIFO head, then direct memory return.
    always_comb begin
        o_rf_wr     = 1'b0;
        o_rf_wraddr = '0;
        o_rf_wrdata = '0;
        fifo_pop    = 1'b0;
        mem_bypass  = 1'b0;
        mem_write   = 1'b0;
        if (i_alu_wb_valid) begin
            o_rf_wraddr = i_alu_wb_addr;
            o_rf_wrdata = i_alu_wb_data;
            o_rf_wr     = (i_alu_wb_addr != '0);
        end else if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            o_rf_wraddr = fifo_head.addr;
            o_rf_wrdata = fifo_head.data;
            o_rf_wr     = (fifo_head.addr != '0);
            mem_write   = o_rf_wr;
        end else if (i_mem_wb_valid) begin
            mem_bypass  = 1'b1;
            o_rf_wraddr = i_mem_wb_addr;
            o_rf_wrdata = i_mem_wb_data;
            o_rf_wr     = (i_mem_wb_addr != '0);
            mem_write   = o_rf_wr;
        end
    end

    assign fifo_push = i_mem_wb_valid && o_mem_wb_ready && !mem_bypass;

    // Hazard detection against the scoreboard minus this cycle's clears.
    always_comb begin
        clear_vec = mem_write ? (NREG'(1) << o_rf_wraddr) : '0;
        eff_busy  = busy_q & ~clear_vec;
        hazard    = ((i_rs1 != '0) && eff_busy[i_rs1])
                 || ((i_rs2 != '0) && eff_busy[i_rs2])
                 || (i_rd_we && eff_busy[i_rd]);
        o_iss_ready = !hazard && (!op_valid_q || i_op_ready);
        accept      = i_iss_valid && o_iss_ready;
        set_vec     = (accept && i_rd_we && i_rd_long && (i_rd != '0))
                    ? (NREG'(1) << i_rd) : '0;
        // Set after clear so a same-cycle set on the same register wins.
        busy_d      = (busy_q & ~clear_vec) | set_vec;
    end

    // Output bundle: load on accept, drop once consumed, otherwise hold.
    always_comb begin
        op_valid_d   = op_valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_rd_d      = op_rd_q;
        op_rd_we_d   = op_rd_we_q;
        op_rd_long_d = op_rd_long_q;
        if (accept) begin
            op_valid_d   = 1'b1;
            op_a_d       = operand_sel(i_rs1, i_rf_rdata1, o_rf_wr, o_rf_wraddr, o_rf_wrdata);
            op_b_d       = operand_sel(i_rs2, i_rf_rdata2, o_rf_wr, o_rf_wraddr, o_rf_wrdata);
            op_rd_d      = i_rd;
            op_rd_we_d   = i_rd_we;
            op_rd_long_d = i_rd_long;
        end else if (i_op_ready) begin
            op_valid_d   = 1'b0;
        end
    end

    // Scoreboard and output-stage registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q       <= '0;
            op_valid_q   <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_rd_q      <= '0;
            op_rd_we_q   <= 1'b0;
            op_rd_long_q <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            op_valid_q   <= op_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_rd_q      <= op_rd_d;
            op_rd_we_q   <= op_rd_we_d;
            op_rd_long_q <= op_rd_long_d;
        end
    end

    assign o_op_valid   = op_valid_q;
    assign o_op_a       = op_a_q;
    assign o_op_b       = op_b_q;
    assign o_op_rd      = op_rd_q;
    assign o_op_rd_we   = op_rd_we_q;
    assign o_op_rd_long = op_rd_long_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed self-checking bench for rf_access_ctrl.
module tb_rf_access_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_iss_valid;
    logic        o_iss_ready;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic        i_rd_we, i_rd_long;
    logic        o_op_valid;
    logic        i_op_ready;
    logic [31:0] o_op_a, o_op_b;
    logic [4:0]  o_op_rd;
    logic        o_op_rd_we, o_op_rd_long;
    logic [4:0]  o_rf_rdaddr1, o_rf_rdaddr2;
    logic [31:0] i_rf_rdata1, i_rf_rdata2;
    logic        o_rf_wr;
    logic [4:0]  o_rf_wraddr;
    logic [31:0] o_rf_wrdata;
    logic        i_alu_wb_valid;
    logic [4:0]  i_alu_wb_addr;
    logic [31:0] i_alu_wb_data;
    logic        i_mem_wb_valid;
    logic        o_mem_wb_ready;
    logic [4:0]  i_mem_wb_addr;
    logic [31:0] i_mem_wb_data;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    rf_access_ctrl #(.WB_DEPTH(2)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_iss_valid    (i_iss_valid),
        .o_iss_ready    (o_iss_ready),
        .i_rs1          (i_rs1),
        .i_rs2          (i_rs2),
        .i_rd           (i_rd),
        .i_rd_we        (i_rd_we),
        .i_rd_long      (i_rd_long),
        .o_op_valid     (o_op_valid),
        .i_op_ready     (i_op_ready),
        .o_op_a         (o_op_a),
        .o_op_b         (o_op_b),
        .o_op_rd        (o_op_rd),
        .o_op_rd_we     (o_op_rd_we),
        .o_op_rd_long   (o_op_rd_long),
        .o_rf_rdaddr1   (o_rf_rdaddr1),
        .o_rf_rdaddr2   (o_rf_rdaddr2),
        .i_rf_rdata1    (i_rf_rdata1),
        .i_rf_rdata2    (i_rf_rdata2),
        .o_rf_wr        (o_rf_wr),
        .o_rf_wraddr    (o_rf_wraddr),
        .o_rf_wrdata    (o_rf_wrdata),
        .i_alu_wb_valid (i_alu_wb_valid),
        .i_alu_wb_addr  (i_alu_wb_addr),
        .i_alu_wb_data  (i_alu_wb_data),
        .i_mem_wb_valid (i_mem_wb_valid),
        .o_mem_wb_ready (o_mem_wb_ready),
        .i_mem_wb_addr  (i_mem_wb_addr),
        .i_mem_wb_data  (i_mem_wb_data)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic idle();
        i_iss_valid    = 1'b0;
        i_rs1          = '0;
        i_rs2          = '0;
        i_rd           = '0;
        i_rd_we        = 1'b0;
        i_rd_long      = 1'b0;
        i_op_ready     = 1'b1;
        i_rf_rdata1    = '0;
        i_rf_rdata2    = '0;
        i_alu_wb_valid = 1'b0;
        i_alu_wb_addr  = '0;
        i_alu_wb_data  = '0;
        i_mem_wb_valid = 1'b0;
        i_mem_wb_addr  = '0;
        i_mem_wb_data  = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic lng);
        i_iss_valid = 1'b1;
        i_rs1       = rs1;
        i_rs2       = rs2;
        i_rd        = rd;
        i_rd_we     = we;
        i_rd_long   = lng;
    endtask

    task automatic alu_wb(input logic [4:0] addr, input logic [31:0] data);
        i_alu_wb_valid = 1'b1;
        i_alu_wb_addr  = addr;
        i_alu_wb_data  = data;
    endtask

    task automatic mem_wb(input logic [4:0] addr, input logic [31:0] data);
        i_mem_wb_valid = 1'b1;
        i_mem_wb_addr  = addr;
        i_mem_wb_data  = data;
    endtask

    initial begin
        idle();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        settle();

        // 1. Reset state and basic operand capture.
        check("rst_op_valid", 32'(o_op_valid), 32'd0);
        check("rst_op_a", o_op_a, 32'h0);
        check("rst_rf_wr", 32'(o_rf_wr), 32'd0);
        check("rst_mem_ready", 32'(o_mem_wb_ready), 32'd1);
        issue(5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        i_rf_rdata1 = 32'h11;
        i_rf_rdata2 = 32'h22;
        settle();
        check("t1_rdaddr1", 32'(o_rf_rdaddr1), 32'd1);
        check("t1_rdaddr2", 32'(o_rf_rdaddr2), 32'd2);
        check("t1_iss_ready", 32'(o_iss_ready), 32'd1);
        step();
        check("t1_op_valid", 32'(o_op_valid), 32'd1);
        check("t1_op_a", o_op_a, 32'h11);
        check("t1_op_b", o_op_b, 32'h22);
        idle();
        step();
        check("t1_drop_valid", 32'(o_op_valid), 32'd0);

        // 2. x0 reads zero, ALU write to x0 dropped, ALU bypass into operand.
        issue(5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
        i_rf_rdata1 = 32'hDEAD;
        i_rf_rdata2 = 32'h33;
        alu_wb(5'd0, 32'h99);
        settle();
        check("t2_x0_wr", 32'(o_rf_wr), 32'd0);
        step();
        check("t2_op_a_x0", o_op_a, 32'h0);
        check("t2_op_b", o_op_b, 32'h33);
        issue(5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        i_rf_rdata1 = 32'hBAD;
        alu_wb(5'd4, 32'h44);
        settle();
        check("t2_alu_wr", 32'(o_rf_wr), 32'd1);
        check("t2_alu_wraddr", 32'(o_rf_wraddr), 32'd4);
        step();
        check("t2_alu_bypass", o_op_a, 32'h44);
        idle();
        step();

        // 3. Long-latency rd=5 blocks RAW and WAW until the memory return.
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
        step();
        check("t3_op_rd", 32'(o_op_rd), 32'd5);
        check("t3_op_rd_long", 32'(o_op_rd_long), 32'd1);
        check("t3_op_rd_we", 32'(o_op_rd_we), 32'd1);
        issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        i_rf_rdata1 = 32'h1;
        settle();
        check("t3_raw_stall", 32'(o_iss_ready), 32'd0);
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        settle();
        check("t3_waw_stall", 32'(o_iss_ready), 32'd0);
        issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        mem_wb(5'd5, 32'hCAFE);
        settle();
        check("t3_release_ready", 32'(o_iss_ready), 32'd1);
        check("t3_mem_direct_wr", 32'(o_rf_wr), 32'd1);
        check("t3_mem_direct_addr", 32'(o_rf_wraddr), 32'd5);
        check("t3_mem_direct_data", o_rf_wrdata, 32'hCAFE);
        step();
        check("t3_op_a_bypass", o_op_a, 32'hCAFE);
        idle();
        issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        settle();
        check("t3_busy_cleared", 32'(o_iss_ready), 32'd1);
        idle();
        step();
        step();

        // 4. ALU and memory writebacks collide for 3 cycles; FIFO fills, then drains in order.
        alu_wb(5'd10, 32'hA0);
        mem_wb(5'd11, 32'hB1);
        settle();
        check("t4_c1_wraddr", 32'(o_rf_wraddr), 32'd10);
        check("t4_c1_ready", 32'(o_mem_wb_ready), 32'd1);
        step();
        alu_wb(5'd12, 32'hA2);
        mem_wb(5'd13, 32'hB3);
        settle();
        check("t4_c2_wraddr", 32'(o_rf_wraddr), 32'd12);
        check("t4_c2_ready", 32'(o_mem_wb_ready), 32'd1);
        step();
        alu_wb(5'd14, 32'hA4);
        mem_wb(5'd15, 32'hB5);
        settle();
        check("t4_c3_wraddr", 32'(o_rf_wraddr), 32'd14);
        check("t4_c3_wrdata", o_rf_wrdata, 32'hA4);
        check("t4_c3_full", 32'(o_mem_wb_ready), 32'd0);
        step();
        i_alu_wb_valid = 1'b0;
        settle();
        check("t4_d1_addr", 32'(o_rf_wraddr), 32'd11);
        check("t4_d1_data", o_rf_wrdata, 32'hB1);
        check("t4_d1_ready", 32'(o_mem_wb_ready), 32'd0);
        step();
        settle();
        check("t4_d2_ready", 32'(o_mem_wb_ready), 32'd1);
        check("t4_d2_addr", 32'(o_rf_wraddr), 32'd13);
        check("t4_d2_data", o_rf_wrdata, 32'hB3);
        step();
        i_mem_wb_valid = 1'b0;
        settle();
        check("t4_d3_addr", 32'(o_rf_wraddr), 32'd15);
        check("t4_d3_data", o_rf_wrdata, 32'hB5);
        step();
        check("t4_empty_wr", 32'(o_rf_wr), 32'd0);

        // 5. Downstream backpressure holds the bundle; release gives one bundle per cycle.
        idle();
        i_op_ready = 1'b0;
        issue(5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        i_rf_rdata1 = 32'h51;
        step();
        check("t5_first_a", o_op_a, 32'h51);
        issue(5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        i_rf_rdata1 = 32'h52;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("t5_hold_ready%0d", i), 32'(o_iss_ready), 32'd0);
            step();
            check($sformatf("t5_hold_a%0d", i), o_op_a, 32'h51);
            check($sformatf("t5_hold_valid%0d", i), 32'(o_op_valid), 32'd1);
        end
        i_op_ready = 1'b1;
        settle();
        check("t5_release_ready", 32'(o_iss_ready), 32'd1);
        step();
        check("t5_second_a", o_op_a, 32'h52);
        issue(5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        i_rf_rdata1 = 32'h53;
        step();
        check("t5_third_a", o_op_a, 32'h53);
        check("t5_third_valid", 32'(o_op_valid), 32'd1);
        idle();
        step();
        check("t5_drain_valid", 32'(o_op_valid), 32'd0);

        // 6. Reset mid-operation clears scoreboard, FIFO and held bundle.
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
        step();
        issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        alu_wb(5'd20, 32'hE0);
        mem_wb(5'd9, 32'h99);
        step();
        idle();
        i_op_ready = 1'b0;
        issue(5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        settle();
        check("t6_busy3_stall", 32'(o_iss_ready), 32'd0);
        check("t6_fifo_pending", 32'(o_rf_wraddr), 32'd9);
        i_iss_valid = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_op_ready = 1'b1;
        settle();
        check("t6_rst_valid", 32'(o_op_valid), 32'd0);
        check("t6_rst_op_rd", 32'(o_op_rd), 32'd0);
        check("t6_rst_fifo_wr", 32'(o_rf_wr), 32'd0);
        check("t6_rst_mem_ready", 32'(o_mem_wb_ready), 32'd1);
        issue(5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        settle();
        check("t6_rs7_ready", 32'(o_iss_ready), 32'd1);
        issue(5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        i_rf_rdata1 = 32'h3;
        settle();
        check("t6_rs3_ready", 32'(o_iss_ready), 32'd1);
        step();
        check("t6_rs3_valid", 32'(o_op_valid), 32'd1);
        check("t6_rs3_a", o_op_a, 32'h3);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
